// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the CPU, VGA and RAM sides of the memory arbiter into one interface.
//   CPU side : cpu_req, cpu_wren, cpu_addr, cpu_wdata -> arbiter
//              cpu_stall, cpu_rvalid, cpu_rdata        <- arbiter
//   VGA side : vga_req, vga_addr                       -> arbiter
//              vga_gnt, vga_rvalid, vga_rdata          <- arbiter
//   RAM side : ram_wEn, ram_addr, ram_dataIn           <- arbiter
//              ram_dataOut (1-cycle registered read)   -> arbiter
// Modports:
//   slave  - the arbiter's view
//   master - the view of the requesters and the RAM that surround it
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              cpu_req;
   logic              cpu_wren;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              vga_req;
   logic [ADDR_W-1:0] vga_addr;
   logic              vga_gnt;
   logic              vga_rvalid;
   logic [DATA_W-1:0] vga_rdata;

   logic              ram_wEn;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_dataIn;
   logic [DATA_W-1:0] ram_dataOut;

   modport slave (
      input  cpu_req, cpu_wren, cpu_addr, cpu_wdata,
      input  vga_req, vga_addr,
      input  ram_dataOut,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      output vga_gnt, vga_rvalid, vga_rdata,
      output ram_wEn, ram_addr, ram_dataIn
   );

   modport master (
      output cpu_req, cpu_wren, cpu_addr, cpu_wdata,
      output vga_req, vga_addr,
      output ram_dataOut,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      input  vga_gnt, vga_rvalid, vga_rdata,
      input  ram_wEn, ram_addr, ram_dataIn
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port RAM between a CPU (reads and writes) and a VGA frame
// reader (reads only). The CPU normally wins; the VGA reader wins whenever the
// CPU is idle, and is forced through once it has been denied STARVE_LIMIT
// consecutive cycles (legal range 1..255). Read data comes back exactly one
// cycle after the grant, steered to whichever requester owned that read.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous, active-low; gates all grants while low
//   bus   - mem_arbiter_if.slave carrying the CPU, VGA and RAM signals
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          clock,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      WIN_NONE,
      WIN_CPU,
      WIN_VGA
   } winner_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_CPU_RD,
      OWN_VGA_RD
   } owner_t;

   winner_t           w_winner;
   owner_t            r_owner;
   owner_t            w_owner_next;
   logic [7:0]        r_wait_cnt;
   logic [7:0]        w_wait_next;

   logic              w_force;
   logic              w_cpu_stall;
   logic              w_vga_gnt;
   logic              w_ram_wEn;
   logic [ADDR_W-1:0] w_ram_addr;
   logic              w_cpu_rvalid;
   logic              w_vga_rvalid;
   logic [DATA_W-1:0] w_cpu_rdata;
   logic [DATA_W-1:0] w_vga_rdata;

   // ---------------- grant decision ----------------
   assign w_force = bus.vga_req && (r_wait_cnt == LIMIT);

   // reset low forces "no winner", which gates every combinational output
   always_comb begin
      w_winner = WIN_NONE;
      if (reset) begin
         if (w_force) begin
            w_winner = WIN_VGA;
         end else if (bus.cpu_req) begin
            w_winner = WIN_CPU;
         end else if (bus.vga_req) begin
            w_winner = WIN_VGA;
         end
      end
   end

   assign w_vga_gnt   = (w_winner == WIN_VGA);
   assign w_cpu_stall = bus.cpu_req && w_vga_gnt;
   assign w_ram_wEn   = (w_winner == WIN_CPU) && bus.cpu_wren;

   always_comb begin
      w_ram_addr = '0;
      case (w_winner)
         WIN_CPU: w_ram_addr = bus.cpu_addr;
         WIN_VGA: w_ram_addr = bus.vga_addr;
         default: w_ram_addr = '0;
      endcase
   end

   // ---------------- starvation counter ----------------
   // Counts cycles the VGA reader was requesting but lost to the CPU; it stops
   // at LIMIT, which is exactly when the force condition takes over.
   always_comb begin
      w_wait_next = r_wait_cnt;
      if (w_vga_gnt || !bus.vga_req) begin
         w_wait_next = '0;
      end else if ((w_winner == WIN_CPU) && (r_wait_cnt != LIMIT)) begin
         w_wait_next = r_wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wait_cnt <= '0;
      end else begin
         r_wait_cnt <= w_wait_next;
      end
   end

   // ---------------- return-owner FSM ----------------
   // Remembers who issued the read the RAM is answering next cycle. A CPU
   // write produces no return data, so it leaves the owner at NONE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_owner <= OWN_NONE;
      end else begin
         r_owner <= w_owner_next;
      end
   end

   always_comb begin
      w_owner_next = OWN_NONE;
      case (w_winner)
         WIN_CPU: w_owner_next = bus.cpu_wren ? OWN_NONE : OWN_CPU_RD;
         WIN_VGA: w_owner_next = OWN_VGA_RD;
         default: w_owner_next = OWN_NONE;
      endcase
   end

   assign w_cpu_rvalid = (r_owner == OWN_CPU_RD);
   assign w_vga_rvalid = (r_owner == OWN_VGA_RD);

   // read data is zeroed toward the requester that does not own the return
   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_rdata
      assign w_cpu_rdata[gi] = bus.ram_dataOut[gi] & w_cpu_rvalid;
      assign w_vga_rdata[gi] = bus.ram_dataOut[gi] & w_vga_rvalid;
   end

   // ---------------- outputs ----------------
   assign bus.cpu_stall  = w_cpu_stall;
   assign bus.cpu_rvalid = w_cpu_rvalid;
   assign bus.cpu_rdata  = w_cpu_rdata;
   assign bus.vga_gnt    = w_vga_gnt;
   assign bus.vga_rvalid = w_vga_rvalid;
   assign bus.vga_rdata  = w_vga_rdata;
   assign bus.ram_wEn    = w_ram_wEn;
   assign bus.ram_addr   = w_ram_addr;
   assign bus.ram_dataIn = bus.cpu_wdata;

endmodule
